// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the word-organised data memory.
`timescale 1ns/1ps
package data_memory_pkg;

  typedef enum logic {INIT, READY} dmem_state_t;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  // Replace each strobed byte lane of old_word with the same lane of new_word.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [STRB_W-1:0] strobe
  );
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < STRB_W; i++)
      if (strobe[i]) res[8*i +: 8] = new_word[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/data_memory_byte_merge_lanes.sv
// Combinational 4-lane byte merge, shared by the array commit and forward paths.
`timescale 1ns/1ps
module byte_merge_lanes
  import data_memory_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] new_word,
  input  logic [STRB_W-1:0] strobe,
  output logic [WORD_W-1:0] merged
);

  assign merged = byte_merge(old_word, new_word, strobe);

endmodule

// File: rtl/data_memory.sv
// Data memory: 1-cycle loads, one-entry posted write buffer with byte forwarding,
// and a post-reset clear sequence that zeroes every word before going ready.
`timescale 1ns/1ps
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_ready,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_address,
  output logic [31:0]       read_data,
  output logic              read_data_valid,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [31:0]       write_data,
  input  logic [3:0]        write_strobe
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int WORDS = 2 ** IDX_W;

  logic [WORD_W-1:0] mem [WORDS];

  dmem_state_t       state, state_nxt;
  logic [IDX_W-1:0]  init_cnt;

  logic              wb_valid;
  logic [IDX_W-1:0]  wb_word;
  logic [WORD_W-1:0] wb_data;
  logic [STRB_W-1:0] wb_strobe;

  logic              rd_acc, wr_acc;
  logic [IDX_W-1:0]  rd_word, wr_word;
  logic [STRB_W-1:0] fwd_strb;
  logic [WORD_W-1:0] commit_word, load_word;
  logic              unused_addr_lsbs;

  assign rd_word          = read_address[ADDR_W-1:2];
  assign wr_word          = write_address[ADDR_W-1:2];
  assign unused_addr_lsbs = ^{read_address[1:0], write_address[1:0]};

  assign mem_ready = (state == READY);
  assign rd_acc    = read_enable  & mem_ready;
  assign wr_acc    = write_enable & mem_ready;

  // Only the store from the immediately preceding cycle can be in flight.
  assign fwd_strb = (wb_valid && wb_word == rd_word) ? wb_strobe : '0;

  byte_merge_lanes u_commit_merge (
    .old_word (mem[wb_word]),
    .new_word (wb_data),
    .strobe   (wb_strobe),
    .merged   (commit_word)
  );

  byte_merge_lanes u_fwd_merge (
    .old_word (mem[rd_word]),
    .new_word (wb_data),
    .strobe   (fwd_strb),
    .merged   (load_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && init_cnt == IDX_W'(WORDS - 1)) state_nxt = READY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_word   <= '0;
      wb_data   <= '0;
      wb_strobe <= '0;
    end else begin
      wb_valid <= wr_acc;
      if (wr_acc) begin
        wb_word   <= wr_word;
        wb_data   <= write_data;
        wb_strobe <= write_strobe;
      end
    end
  end

  // Array has no reset: the clear sequence zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == INIT)  mem[init_cnt] <= '0;
    else if (wb_valid)  mem[wb_word]  <= commit_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data       <= '0;
      read_data_valid <= 1'b0;
    end else begin
      read_data_valid <= rd_acc;
      if (rd_acc) read_data <= load_word;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: clear sequence, stores, forwarding, resets.
`timescale 1ns/1ps
module tb_data_memory;

  localparam int ADDR_W = 10;
  localparam int WORDS  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_ready;
  logic              read_enable;
  logic [ADDR_W-1:0] read_address;
  logic [31:0]       read_data;
  logic              read_data_valid;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [31:0]       write_data;
  logic [3:0]        write_strobe;

  int tests = 0;
  int fails = 0;

  data_memory #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_ready       (mem_ready),
    .read_enable     (read_enable),
    .read_address    (read_address),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .write_data      (write_data),
    .write_strobe    (write_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  task automatic set_store(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
    write_enable  = 1'b1;
    write_address = a;
    write_data    = d;
    write_strobe  = s;
  endtask

  task automatic set_load(input logic [ADDR_W-1:0] a);
    read_enable  = 1'b1;
    read_address = a;
  endtask

  // Issue a lone load, advance one cycle, check the returned word.
  task automatic load_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    idle();
    set_load(a);
    tick();
    idle();
    chk(tag, read_data, exp);
    chk({tag, "_vld"}, {31'd0, read_data_valid}, 32'd1);
  endtask

  // Count negedges from release until mem_ready is seen high; also watch valid.
  task automatic wait_ready(input string tag);
    int n;
    logic saw_vld;
    n = 0;
    saw_vld = 1'b0;
    while (mem_ready !== 1'b1 && n < 1000) begin
      tick();
      idle();
      n++;
      if (read_data_valid) saw_vld = 1'b1;
    end
    chk({tag, "_cycles"}, n, WORDS);
    chk({tag, "_vld_init"}, {31'd0, saw_vld}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    read_address = '0; write_address = '0; write_data = '0; write_strobe = '0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_vld",   {31'd0, read_data_valid}, 32'd0);

    // Release with a store and load pending: both must be dropped during INIT.
    rst_n = 1'b1;
    set_store(10'h000, 32'hFFFF_FFFF, 4'hF);
    set_load(10'h000);
    wait_ready("init1");
    load_chk("init_store_dropped", 10'h000, 32'h0);

    // Full-word store, load two cycles later from the array.
    set_store(10'h040, 32'h1234_5678, 4'hF);
    tick(); idle(); tick();
    load_chk("full_store", 10'h040, 32'h1234_5678);

    // Partial store forwarded to the very next load, then read back from array.
    set_store(10'h040, 32'h0000_AB00, 4'b0010);
    tick();
    load_chk("fwd_partial", 10'h040, 32'h1234_AB78);
    load_chk("array_partial", 10'h040, 32'h1234_AB78);
    load_chk("addr_lsbs_ignored", 10'h043, 32'h1234_AB78);

    // Idle cycle: data holds, valid drops.
    tick();
    chk("idle_hold", read_data, 32'h1234_AB78);
    chk("idle_vld",  {31'd0, read_data_valid}, 32'd0);

    // Same-cycle load and store to one word.
    set_store(10'h080, 32'h1111_1111, 4'hF);
    tick(); idle(); tick();
    set_load(10'h080);
    set_store(10'h080, 32'h2222_2222, 4'hF);
    tick();
    idle();
    chk("same_cycle_old", read_data, 32'h1111_1111);
    load_chk("same_cycle_next", 10'h080, 32'h2222_2222);

    // Zero-strobe store changes nothing, even on the forward path.
    set_store(10'h080, 32'hFFFF_FFFF, 4'h0);
    tick();
    load_chk("zero_strobe", 10'h080, 32'h2222_2222);

    // Back-to-back stores to one word with a load between them.
    set_store(10'h080, 32'h0000_00AA, 4'b0001);
    tick();
    set_store(10'h080, 32'hBB00_0000, 4'b1000);
    set_load(10'h080);
    tick();
    idle();
    chk("b2b_fwd", read_data, 32'h2222_22AA);
    load_chk("b2b_fwd2", 10'h080, 32'hBB22_22AA);
    load_chk("b2b_array", 10'h080, 32'hBB22_22AA);

    // Word 5 preload, confirmed before the next reset wipes it.
    set_store(10'h014, 32'hDEAD_BEEF, 4'hF);
    tick(); idle(); tick();
    load_chk("preload", 10'h014, 32'hDEAD_BEEF);

    // Reset mid-operation with a store still in the write buffer.
    set_store(10'h008, 32'hCAFE_F00D, 4'hF);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("mid_rst_rdata", read_data, 32'd0);
    chk("mid_rst_vld",   {31'd0, read_data_valid}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready("init2");
    load_chk("mid_rst_store_lost", 10'h008, 32'h0);
    load_chk("clear_word5", 10'h014, 32'h0);
    load_chk("clear_word16", 10'h040, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory that sits directly downstream of the execute-stage `memory_access` unit and consumes its read/write requests. It stores 32-bit words in an internal register array, returns load data one cycle after the request, and posts stores through a one-entry write buffer with byte-lane forwarding to back-to-back loads. After every reset it runs a clear sequence that zeroes the whole array before it accepts requests.

## Interface
- `ADDR_W`, 10: byte-address width. Word count `WORDS = 2**(ADDR_W-2)`, so the default is 256 words.
- `clk` input, 1 bit: single clock, all state on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `mem_ready` output, 1 bit: high when requests are accepted; low during the clear sequence.
- `read_enable` input, 1 bit: load request this cycle.
- `read_address` input, `ADDR_W` bits: load byte address. Bits [1:0] are ignored.
- `read_data` output, 32 bits: registered full word, with all four byte lanes.
- `read_data_valid` output, 1 bit: `read_data` holds the word for the load issued in the previous cycle.
- `write_enable` input, 1 bit: store request this cycle.
- `write_address` input, `ADDR_W` bits: store byte address. Bits [1:0] are ignored.
- `write_data` input, 32 bits: store data, already lane-aligned by upstream.
- `write_strobe` input, 4 bits: byte-lane enables. Bit i enables `write_data[8i+7:8i]`.

## Operation
- The state machine has two states, INIT and READY. Reset forces INIT.
- **INIT**
  - `init_cnt` counts from 0 to WORDS-1, one word per cycle, and writes 0 into each word.
  - At `init_cnt == WORDS-1` the state moves to READY on the next edge.
  - `mem_ready` is 0 throughout INIT.
- **READY**
  - `mem_ready` is 1.
  - The machine stays in READY until reset.
- Requests arriving while `mem_ready` is 0 are dropped with no side effects. `read_data_valid` stays 0 for them.
- **Write buffer**
  - The buffer holds one entry: `wb_valid`, `wb_word`, `wb_data`, `wb_strobe`.
  - An accepted store in cycle N loads the buffer at the end of cycle N.
  - In cycle N+1 the buffered entry commits to `array[wb_word]` at the end of the cycle. Only the strobed lanes change.
  - A new store in cycle N+1 reloads the buffer on the same edge. No stall is ever needed.
  - If no store is accepted in a cycle, `wb_valid` clears at the end of that cycle.
  - A store with `write_strobe == 0` is accepted but changes nothing.
- **Load**
  - An accepted load in cycle M registers its result at the end of M.
  - The result is `array[read_word]`. If `wb_valid` is set and `wb_word == read_word`, strobed lanes come from `wb_data` instead.
  - A store presented in the same cycle M is not visible to that load; the load returns the old value.
- Simultaneous load and store in one cycle are both accepted, to the same or different words.
- If `read_enable` is 0, `read_data` holds its last value and `read_data_valid` drops to 0.
- Upstream `memory_access` performs sign and zero extension. This block always returns the full word.

## Timing
- Reset values:
  - Outputs: `mem_ready` 0, `read_data` 0, `read_data_valid` 0.
  - Internal: state INIT, `init_cnt` 0, `wb_valid` 0.
- Asserting reset mid-operation discards any pending buffered store, restarts INIT from word 0, and re-clears the entire array.
- The first request is accepted WORDS cycles after `rst_n` rises. `mem_ready` rises on the edge where the state becomes READY.
- Load latency is 1 cycle, and the block sustains one load and one store per cycle.
- Store visibility:
  - A load in N+1 sees a store from N via forwarding.
  - A load in N+2 or later sees it from the array.

## Structure
- Package `data_memory_pkg` holds:
  - `typedef enum logic {INIT, READY} dmem_state_t`
  - `WORD_W = 32` and `STRB_W = 4`
  - function `byte_merge(old, new, strobe)`
- One sub-module, `byte_merge_lanes`, performs the combinational 4-lane merge. It is used both for the array commit and for the forward path.
- Expected implementation is roughly 150–200 lines in total.

## Test plan
- **Reset and clear:** preload array word 5 = 32'hDEADBEEF via backdoor, then pulse `rst_n`. Required: `mem_ready` = 0 for exactly 256 cycles, then 1. A load from 0x14 then returns 0.
- **Full-word store/load:** store 32'h12345678 to 0x40 with strobe 4'hF; two cycles later load 0x40. Required: `read_data` = 32'h12345678 with `read_data_valid` = 1, one cycle after the load.
- **Forwarding with partial strobe:** word 0x40 = 32'h12345678; store 32'h0000AB00 with strobe 4'b0010 in cycle N, then load 0x40 in N+1. Required: 32'h1234AB78.
- **Same-cycle load and store to one word:** word = 32'h11111111; load and store (32'h22222222, strobe 4'hF) together. Required: load returns 32'h11111111, and a load in the next cycle returns 32'h22222222.
- **Requests during INIT:** issue a store to 0x0 during INIT, then load 0x0 after ready. Required: `read_data_valid` stays 0 during INIT and the later load returns 0.
- **Reset mid-operation:** store to 0x8, assert `rst_n` = 0 in the next cycle, then release. Required: outputs at reset values, INIT repeated, and a load from 0x8 returns 0.
